exec_unit: RTL and testbench

//  Execute/writeback stage of TinyCPU. Accepts one decoded instruction per handshake.

---
 rtl/tinycpu_pkg.sv | 28 ++
 rtl/mul_seq8.sv | 49 ++++
 rtl/exec_unit.sv | 207 ++++++++++++++++++++
 tb/tb_exec_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinycpu_pkg.sv
// TinyCPU shared definitions: default widths, opcode values and the exec-stage FSM encoding.
// Used by the decoder and by exec_unit.
package tinycpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int OP_W_DEF   = 4;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_WB   = 2'd3
    } exec_state_t;

endpackage

// File: rtl/mul_seq8.sv
// Sequential 8x8 shift-add multiplier: one multiplier bit per cycle, 8 cycles after start.
// o_done is high during the final cycle, when o_product already holds the full product.
module mul_seq8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic        o_done,
    output logic [15:0] o_product
);

    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [2:0]  r_count;
    logic        r_busy;
    logic [15:0] w_accNext;

    // The product is exposed one step early so the caller can leave on the last bit's edge.
    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : 16'd0);
    assign o_done    = r_busy && (r_count == 3'd7);
    assign o_product = w_accNext;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {8'd0, i_a};
            r_mplier <= i_b;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_accNext;
            r_mcand  <= {r_mcand[14:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[7:1]};
            r_count  <= r_count + 3'd1;
            if (r_count == 3'd7) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// TinyCPU execute/writeback stage: reads operands in EXEC, writes the result back in WB.
// Define EXEC_MUL_EN to add the 8-cycle MUL opcode; otherwise opcode A is illegal.
module exec_unit
    import tinycpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] r_addr_a,
    output logic [ADDR_W-1:0] r_addr_b,
    input  logic [DATA_W-1:0] r_data_a,
    input  logic [DATA_W-1:0] r_data_b,
    output logic              we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy,
    output logic              illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              carry;
        logic              setsFlags;
        logic              writes;
        logic              toMul;
        logic              legal;
    } alu_out_t;

    exec_state_t       r_state;
    exec_state_t       w_nextState;
    logic [OP_W-1:0]   r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [ADDR_W-1:0] r_addrA;
    logic [ADDR_W-1:0] r_addrB;
    logic [ADDR_W-1:0] r_wAddr;
    logic [DATA_W-1:0] r_wData;
    logic              r_flagZ;
    logic              r_flagC;
    alu_out_t          w_alu;

    function automatic alu_out_t alu_eval(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] imm);
        alu_out_t   o;
        logic [DATA_W:0] wide;
        o           = '0;
        wide        = '0;
        o.legal     = 1'b1;
        o.setsFlags = 1'b1;
        o.writes    = 1'b1;
        case (op)
            OP_ADD: begin
                wide    = {1'b0, a} + {1'b0, b};
                o.res   = wide[DATA_W-1:0];
                o.carry = wide[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                wide     = {1'b0, a} - {1'b0, b};
                o.res    = wide[DATA_W-1:0];
                o.carry  = wide[DATA_W];
                o.writes = (op != OP_CMP);
            end
            OP_AND: o.res = a & b;
            OP_OR:  o.res = a | b;
            OP_XOR: o.res = a ^ b;
            OP_SHL: begin
                o.res   = {a[DATA_W-2:0], 1'b0};
                o.carry = a[DATA_W-1];
            end
            OP_SHR: begin
                o.res   = {1'b0, a[DATA_W-1:1]};
                o.carry = a[0];
            end
            OP_LDI: begin
                o.res       = imm;
                o.setsFlags = 1'b0;
            end
            OP_MOV: begin
                o.res       = a;
                o.setsFlags = 1'b0;
            end
`ifdef EXEC_MUL_EN
            OP_MUL: begin
                o.writes    = 1'b0;
                o.setsFlags = 1'b0;
                o.toMul     = 1'b1;
            end
`endif
            default: begin
                o.legal     = 1'b0;
                o.writes    = 1'b0;
                o.setsFlags = 1'b0;
            end
        endcase
        return o;
    endfunction

    assign w_alu = alu_eval(r_op, r_data_a, r_data_b, r_imm);

`ifdef EXEC_MUL_EN
    logic        w_mulDone;
    logic [15:0] w_mulProduct;

    mul_seq8 u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   ((r_state == ST_EXEC) && w_alu.toMul),
        .i_a       (r_data_a),
        .i_b       (r_data_b),
        .o_done    (w_mulDone),
        .o_product (w_mulProduct)
    );
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_nextState = ST_EXEC;
            ST_EXEC: begin
                if (w_alu.toMul)       w_nextState = ST_MUL;
                else if (w_alu.writes) w_nextState = ST_WB;
                else                   w_nextState = ST_IDLE;
            end
`ifdef EXEC_MUL_EN
            ST_MUL:  if (w_mulDone) w_nextState = ST_WB;
`else
            ST_MUL:  w_nextState = ST_IDLE;
`endif
            ST_WB:   w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Write port and flags are registered on the way into WB so they hold afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_rd    <= '0;
            r_imm   <= '0;
            r_addrA <= '0;
            r_addrB <= '0;
            r_wAddr <= '0;
            r_wData <= '0;
            r_flagZ <= 1'b0;
            r_flagC <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op    <= in_op;
                        r_rd    <= in_rd;
                        r_imm   <= in_imm;
                        r_addrA <= in_rs1;
                        r_addrB <= in_rs2;
                    end
                end
                ST_EXEC: begin
                    if (w_alu.writes) begin
                        r_wAddr <= r_rd;
                        r_wData <= w_alu.res;
                    end
                    if (w_alu.setsFlags) begin
                        r_flagC <= w_alu.carry;
                        r_flagZ <= (w_alu.res == '0);
                    end
                end
`ifdef EXEC_MUL_EN
                ST_MUL: begin
                    if (w_mulDone) begin
                        r_wAddr <= r_rd;
                        r_wData <= w_mulProduct[7:0];
                        r_flagC <= |w_mulProduct[15:8];
                        r_flagZ <= (w_mulProduct[7:0] == 8'd0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign we       = (r_state == ST_WB);
    assign illegal  = (r_state == ST_EXEC) && !w_alu.legal;
    assign r_addr_a = r_addrA;
    assign r_addr_b = r_addrB;
    assign w_addr   = r_wAddr;
    assign w_data   = r_wData;
    assign flag_z   = r_flagZ;
    assign flag_c   = r_flagC;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with a behavioural 8x8 regfile.
// MUL checks follow EXEC_MUL_EN.
module tb_exec_unit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [2:0] in_rd;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic [7:0] in_imm;
    logic [2:0] r_addr_a;
    logic [2:0] r_addr_b;
    logic [7:0] r_data_a;
    logic [7:0] r_data_b;
    logic       we;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    logic       flag_z;
    logic       flag_c;
    logic       busy;
    logic       illegal;

    logic [7:0] regs [8];
    int nChecks;
    int nErrors;

    exec_unit dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_imm   (in_imm),
        .r_addr_a (r_addr_a),
        .r_addr_b (r_addr_b),
        .r_data_a (r_data_a),
        .r_data_b (r_data_b),
        .we       (we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .busy     (busy),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile: async read, write lands on the rising edge that ends WB.
    assign r_data_a = regs[r_addr_a];
    assign r_data_b = regs[r_addr_b];
    always @(posedge clk) begin
        if (we) regs[w_addr] <= w_data;
    end

    // Issues one instruction and watches 14 cycles; cycle 1 is EXEC, i.e. the cycle after the accept edge.
    task automatic runInstr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic [7:0] imm,
                            output int weAt, output int weCount, output int illCount);
        int waitCnt;
        weAt = -1; weCount = 0; illCount = 0; waitCnt = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (we) begin
                weCount++;
                if (weAt < 0) weAt = k;
            end
            if (illegal) illCount++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if ({in_ready, we, busy, illegal, flag_z, flag_c} !== 6'b100000) begin
            nErrors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 100000", {in_ready, we, busy, illegal, flag_z, flag_c});
        end
        nChecks++;
        if ({w_addr, w_data, r_addr_a, r_addr_b} !== 17'd0) begin
            nErrors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {w_addr, w_data, r_addr_a, r_addr_b});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ldi();
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'h7; in_rd = 3'd1; in_rs1 = 3'd0; in_rs2 = 3'd0; in_imm = 8'h2A;
        nChecks++;
        if (in_ready !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL ldi_ready_idle: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        nChecks++;
        if ({we, busy, in_ready} !== 3'b010) begin
            nErrors++;
            $display("[TB] FAIL ldi_exec_cycle: we/busy/ready got %b expected 010", {we, busy, in_ready});
        end
        @(negedge clk);
        nChecks++;
        if ({we, w_addr, w_data} !== {1'b1, 3'd1, 8'h2A}) begin
            nErrors++;
            $display("[TB] FAIL ldi_wb: we/addr/data got %b/%0d/%h expected 1/1/2a", we, w_addr, w_data);
        end
        @(negedge clk);
        nChecks++;
        if ({we, in_ready, regs[1]} !== {1'b0, 1'b1, 8'h2A}) begin
            nErrors++;
            $display("[TB] FAIL ldi_after: we/ready/r1 got %b/%b/%h expected 0/1/2a", we, in_ready, regs[1]);
        end
    endtask

    task automatic test_add_sub();
        int weAt, weCount, illCount;
        runInstr(4'h7, 3'd1, 3'd0, 3'd0, 8'hF0, weAt, weCount, illCount);
        runInstr(4'h7, 3'd2, 3'd0, 3'd0, 8'h20, weAt, weCount, illCount);
        runInstr(4'h0, 3'd3, 3'd1, 3'd2, 8'h00, weAt, weCount, illCount);
        nChecks++;
        if (weAt !== 2 || weCount !== 1) begin
            nErrors++;
            $display("[TB] FAIL add_latency: weAt/count got %0d/%0d expected 2/1", weAt, weCount);
        end
        nChecks++;
        if ({w_data, regs[3], flag_c, flag_z} !== {8'h10, 8'h10, 1'b1, 1'b0}) begin
            nErrors++;
            $display("[TB] FAIL add_result: data/r3/C/Z got %h/%h/%b/%b expected 10/10/1/0", w_data, regs[3], flag_c, flag_z);
        end
        runInstr(4'h1, 3'd4, 3'd1, 3'd1, 8'h00, weAt, weCount, illCount);
        nChecks++;
        if ({w_data, regs[4], flag_c, flag_z} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
            nErrors++;
            $display("[TB] FAIL sub_result: data/r4/C/Z got %h/%h/%b/%b expected 00/00/0/1", w_data, regs[4], flag_c, flag_z);
        end
    endtask

    task automatic test_cmp();
        int weAt, weCount, illCount;
        logic [7:0] snap [8];
        for (int i = 0; i < 8; i++) snap[i] = regs[i];
        runInstr(4'h9, 3'd5, 3'd2, 3'd1, 8'h00, weAt, weCount, illCount);
        nChecks++;
        if ({flag_c, flag_z} !== 2'b10) begin
            nErrors++;
            $display("[TB] FAIL cmp_flags: C/Z got %b/%b expected 1/0", flag_c, flag_z);
        end
        nChecks++;
        if (weCount !== 0 || illCount !== 0) begin
            nErrors++;
            $display("[TB] FAIL cmp_no_we: we/illegal pulses got %0d/%0d expected 0/0", weCount, illCount);
        end
        for (int i = 0; i < 8; i++) begin
            nChecks++;
            if (regs[i] !== snap[i]) begin
                nErrors++;
                $display("[TB] FAIL cmp_regs_r%0d: got %h expected %h", i, regs[i], snap[i]);
            end
        end
        nChecks++;
        if ({w_addr, w_data} !== {3'd4, 8'h00}) begin
            nErrors++;
            $display("[TB] FAIL cmp_wport_hold: addr/data got %0d/%h expected 4/00", w_addr, w_data);
        end
    endtask

    // r1=F0, r2=20, r4=00 on entry; flags C=1 Z=0 left by CMP.
    task automatic test_alu_ops();
        int weAt, weCount, illCount;
        logic [3:0] ops  [8] = '{4'h2, 4'h3, 4'h4, 4'h8, 4'h5, 4'h6, 4'h1, 4'h0};
        logic [2:0] rs1s [8] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd4};
        logic [2:0] rs2s [8] = '{3'd2, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd4};
        logic [7:0] exps [8] = '{8'h20, 8'hF0, 8'h00, 8'h20, 8'hE0, 8'h10, 8'h30, 8'h00};
        logic [1:0] expCZ[8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
        for (int t = 0; t < 8; t++) begin
            runInstr(ops[t], 3'd5, rs1s[t], rs2s[t], 8'h00, weAt, weCount, illCount);
            nChecks++;
            if ({w_data, regs[5], flag_c, flag_z, weAt[3:0]} !== {exps[t], exps[t], expCZ[t], 4'd2}) begin
                nErrors++;
                $display("[TB] FAIL alu_op%h: data/r5/C/Z/weAt got %h/%h/%b/%b/%0d expected %h/%h/%b/%b/2",
                         ops[t], w_data, regs[5], flag_c, flag_z, weAt, exps[t], exps[t], expCZ[t][1], expCZ[t][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        int acc [$];
        int weT [$];
        logic [2:0] weA [$];
        logic acceptNow;
        logic [7:0] imms [3] = '{8'h11, 8'h22, 8'h33};
        idx = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'h7; in_rd = 3'd5; in_imm = imms[0]; in_rs1 = 3'd0; in_rs2 = 3'd0;
        for (int c = 0; c < 16; c++) begin
            if (we) begin
                weT.push_back(c);
                weA.push_back(w_addr);
            end
            acceptNow = in_ready && in_valid;
            if (acceptNow) acc.push_back(c);
            @(negedge clk);
            if (acceptNow) begin
                idx++;
                if (idx < 3) begin
                    in_rd = 3'(5 + idx);
                    in_imm = imms[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        nChecks++;
        if (acc.size() !== 3 || weT.size() !== 3) begin
            nErrors++;
            $display("[TB] FAIL b2b_counts: accepts/we got %0d/%0d expected 3/3", acc.size(), weT.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nChecks++;
                if (acc[i] !== 3 * i || weT[i] !== 3 * i + 2 || weA[i] !== 3'(5 + i)) begin
                    nErrors++;
                    $display("[TB] FAIL b2b_slot%0d: accept/we/addr got %0d/%0d/%0d expected %0d/%0d/%0d",
                             i, acc[i], weT[i], weA[i], 3 * i, 3 * i + 2, 5 + i);
                end
            end
        end
        nChecks++;
        if ({regs[5], regs[6], regs[7]} !== 24'h112233) begin
            nErrors++;
            $display("[TB] FAIL b2b_regs: got %h%h%h expected 112233", regs[5], regs[6], regs[7]);
        end
    endtask

    // Entry flags: C=0 Z=1 from the last ALU vector (ADD r4,r4).
    task automatic test_illegal_mul();
        int weAt, weCount, illCount;
        runInstr(4'hF, 3'd3, 3'd1, 3'd2, 8'h00, weAt, weCount, illCount);
        nChecks++;
        if (illCount !== 1 || weCount !== 0) begin
            nErrors++;
            $display("[TB] FAIL illegal_F: illegal/we pulses got %0d/%0d expected 1/0", illCount, weCount);
        end
        nChecks++;
        if ({flag_c, flag_z} !== 2'b01) begin
            nErrors++;
            $display("[TB] FAIL illegal_flags: C/Z got %b/%b expected 0/1", flag_c, flag_z);
        end
`ifdef EXEC_MUL_EN
        runInstr(4'h7, 3'd1, 3'd0, 3'd0, 8'h10, weAt, weCount, illCount);
        runInstr(4'h7, 3'd2, 3'd0, 3'd0, 8'h13, weAt, weCount, illCount);
        runInstr(4'hA, 3'd3, 3'd1, 3'd2, 8'h00, weAt, weCount, illCount);
        nChecks++;
        if (weAt !== 10 || weCount !== 1 || illCount !== 0) begin
            nErrors++;
            $display("[TB] FAIL mul_latency: weAt/we/illegal got %0d/%0d/%0d expected 10/1/0", weAt, weCount, illCount);
        end
        nChecks++;
        if ({w_data, regs[3], flag_c, flag_z} !== {8'h30, 8'h30, 1'b1, 1'b0}) begin
            nErrors++;
            $display("[TB] FAIL mul_result: data/r3/C/Z got %h/%h/%b/%b expected 30/30/1/0", w_data, regs[3], flag_c, flag_z);
        end
`else
        runInstr(4'hA, 3'd3, 3'd1, 3'd2, 8'h00, weAt, weCount, illCount);
        nChecks++;
        if (illCount !== 1 || weCount !== 0) begin
            nErrors++;
            $display("[TB] FAIL illegal_A: illegal/we pulses got %0d/%0d expected 1/0", illCount, weCount);
        end
`endif
    endtask

    // Drops reset after holdCycles in-flight cycles (1 = EXEC, 2 = first MUL cycle).
    task automatic resetMidOp(input logic [3:0] op, input int holdCycles, input string name);
        logic [7:0] snap [8];
        int weSeen;
        weSeen = 0;
        for (int i = 0; i < 8; i++) snap[i] = regs[i];
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2; in_imm = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k < holdCycles; k++) begin
            if (we) weSeen++;
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({in_ready, busy, we, flag_c, flag_z} !== 5'b10000) begin
            nErrors++;
            $display("[TB] FAIL %s_state: ready/busy/we/C/Z got %b expected 10000", name, {in_ready, busy, we, flag_c, flag_z});
        end
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (we) weSeen++;
            @(negedge clk);
        end
        nChecks++;
        if (weSeen !== 0 || regs[3] !== snap[3]) begin
            nErrors++;
            $display("[TB] FAIL %s_nowrite: we pulses/r3 got %0d/%h expected 0/%h", name, weSeen, regs[3], snap[3]);
        end
    endtask

    task automatic test_reset_midop();
        resetMidOp(4'h7, 1, "rst_exec");
`ifdef EXEC_MUL_EN
        resetMidOp(4'hA, 2, "rst_mul");
`endif
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        reset = 1'b0;
        in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        test_reset();
        test_ldi();
        test_add_sub();
        test_cmp();
        test_alu_ops();
        test_back_to_back();
        test_illegal_mul();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
